// File: rtl/sparc_mem_ctrl_if.sv
// sparc_mem_ctrl_if: boot stream, CPU MOV/MFC handshake and RAM port bundle for sparc_mem_ctrl.
interface sparc_mem_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              boot_en;
    logic              boot_valid;
    logic [7:0]        boot_data;
    logic              boot_done;
    logic              boot_ready;
    logic              boot_active;
    logic              mov;
    logic              r_w;
    logic [1:0]        mtype;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              mfc;
    logic              misalign_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [7:0]        ram_rdata;

    modport master (
        output boot_en, boot_valid, boot_data, boot_done, mov, r_w, mtype, cpu_addr, cpu_wdata, ram_rdata,
        input  boot_ready, boot_active, cpu_rdata, mfc, misalign_err, ram_addr, ram_wdata, ram_we, ram_re
    );

    modport slave (
        input  boot_en, boot_valid, boot_data, boot_done, mov, r_w, mtype, cpu_addr, cpu_wdata, ram_rdata,
        output boot_ready, boot_active, cpu_rdata, mfc, misalign_err, ram_addr, ram_wdata, ram_we, ram_re
    );
endinterface

// File: rtl/sparc_mem_ctrl.sv
// sparc_mem_ctrl: boot preload and big-endian byte/half/word sequencing for the 512x8 RAM.
// Define SPARC_MEM_SIGNEXT_EN to sign-extend byte and halfword reads.
module sparc_mem_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 512,
    parameter int READ_LAT = 1
) (
    input logic             clk,
    input logic             clr,
    sparc_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, IDLE, ACCESS, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] bcnt, a_q;
    logic [7:0]        wd_q;
    logic              we_q, re_q, rw, fault;
    logic [2:0]        n, k, n_in, last;
    logic [23:0]       wbuf, rbuf;
    logic [31:0]       wal, rval, rext;

    always_comb begin
        n_in  = bus.mtype == 2'b00 ? 3'd1 : bus.mtype == 2'b01 ? 3'd2 : 3'd4;
        fault = bus.mtype == 2'b11 || (bus.mtype == 2'b01 && bus.cpu_addr[0]) ||
                (bus.mtype == 2'b10 && bus.cpu_addr[1:0] != 2'b00);
        wal   = bus.mtype == 2'b00 ? {bus.cpu_wdata[7:0], 24'h0} :
                bus.mtype == 2'b01 ? {bus.cpu_wdata[15:0], 16'h0} : bus.cpu_wdata;
        last  = rw ? n + 3'(READ_LAT) - 3'd1 : n - 3'd1;
        rval  = {rbuf, bus.ram_rdata};
`ifdef SPARC_MEM_SIGNEXT_EN
        rext  = n == 3'd1 ? {{24{rval[7]}}, rval[7:0]} : n == 3'd2 ? {{16{rval[15]}}, rval[15:0]} : rval;
`else
        rext  = n == 3'd1 ? {24'h0, rval[7:0]} : n == 3'd2 ? {16'h0, rval[15:0]} : rval;
`endif
    end

    // Boot writes go straight through in the cycle boot_valid is seen.
    assign bus.boot_ready  = state == BOOT;
    assign bus.boot_active = state == BOOT;
    assign bus.ram_we      = state == BOOT ? bus.boot_valid : we_q;
    assign bus.ram_addr    = state == BOOT ? bcnt : a_q;
    assign bus.ram_wdata   = state == BOOT ? bus.boot_data : wd_q;
    assign bus.ram_re      = re_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state            <= bus.boot_en ? BOOT : IDLE;
            bcnt             <= '0;
            a_q              <= '0;
            wd_q             <= '0;
            we_q             <= 1'b0;
            re_q             <= 1'b0;
            rw               <= 1'b0;
            n                <= 3'd1;
            k                <= 3'd0;
            wbuf             <= '0;
            rbuf             <= '0;
            bus.mfc          <= 1'b0;
            bus.misalign_err <= 1'b0;
            bus.cpu_rdata    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (bus.boot_valid) bcnt <= bcnt + 1'b1;
                    if ((bus.boot_valid && bcnt == ADDR_W'(DEPTH - 1)) || bus.boot_done) state <= IDLE;
                end
                IDLE: if (bus.mov) begin
                    rw   <= bus.r_w;
                    n    <= n_in;
                    k    <= 3'd0;
                    rbuf <= '0;
                    if (fault) begin
                        state            <= DONE;
                        bus.mfc          <= 1'b1;
                        bus.misalign_err <= 1'b1;
                    end else begin
                        state <= ACCESS;
                        a_q   <= bus.cpu_addr;
                        we_q  <= !bus.r_w;
                        re_q  <= bus.r_w;
                        wd_q  <= wal[31:24];
                        wbuf  <= wal[23:0];
                    end
                end
                ACCESS: begin
                    k <= k + 3'd1;
                    if (k + 3'd1 < n) begin
                        a_q  <= a_q + 1'b1;
                        wd_q <= wbuf[23:16];
                        wbuf <= {wbuf[15:0], 8'h0};
                    end else begin
                        we_q <= 1'b0;
                        re_q <= 1'b0;
                    end
                    // Read bytes arrive READ_LAT cycles behind their issue, oldest first.
                    if (rw && k >= 3'(READ_LAT)) rbuf <= rval[23:0];
                    if (k == last) begin
                        state   <= DONE;
                        bus.mfc <= 1'b1;
                        if (rw) bus.cpu_rdata <= rext;
                    end
                end
                DONE: if (!bus.mov) begin
                    state            <= IDLE;
                    bus.mfc          <= 1'b0;
                    bus.misalign_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// tb_sparc_mem_ctrl: randomized and directed checks of sparc_mem_ctrl against a byte-array reference model.
module tb_sparc_mem_ctrl;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    sparc_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus();
    sparc_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(1)) dut (.clk(clk), .clr(clr), .bus(bus));

    logic [7:0]  mem [DEPTH];
    logic [7:0]  exp_mem [DEPTH];
    logic [7:0]  rdq = 8'h0;
    logic [31:0] exp_rd = 32'h0;
    int compared = 0, mismatched = 0;
    int we_cnt = 0, re_cnt = 0, both_cnt = 0;

    assign bus.ram_rdata = rdq;

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re) rdq <= mem[bus.ram_addr];
        if (bus.ram_we) we_cnt <= we_cnt + 1;
        if (bus.ram_re) re_cnt <= re_cnt + 1;
        if (bus.ram_we && bus.ram_re) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic int nbytes(input logic [1:0] t);
        return t == 2'd0 ? 1 : t == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic is_fault(input logic [1:0] t, input logic [8:0] a);
        return t == 2'd3 || (t == 2'd1 && a % 2 != 0) || (t == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] exp_read(input int nb, input int a);
        logic [31:0] v = 0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(exp_mem[a + i]);
`ifdef SPARC_MEM_SIGNEXT_EN
        if (nb == 1 && v[7]) v = v | 32'hFFFFFF00;
        if (nb == 2 && v[15]) v = v | 32'hFFFF0000;
`endif
        return v;
    endfunction

    task automatic do_req(input logic rw, input logic [1:0] t, input logic [8:0] a, input logic [31:0] wd,
                          output int lat, output int wes, output int res);
        int w0, r0;
        @(negedge clk);
        bus.mov = 1'b1; bus.r_w = rw; bus.mtype = t; bus.cpu_addr = a; bus.cpu_wdata = wd;
        w0 = we_cnt; r0 = re_cnt; lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.mfc && lat < 30);
        wes = we_cnt - w0; res = re_cnt - r0;
    endtask

    task automatic finish_req(output logic held, output logic mfc_after, output logic err_after);
        @(negedge clk);
        held = bus.mfc;
        bus.mov = 1'b0;
        @(negedge clk);
        mfc_after = bus.mfc; err_after = bus.misalign_err;
    endtask

    task automatic test_reset;
        bus.boot_en = 1'b0; bus.boot_valid = 1'b0; bus.boot_data = 8'h0; bus.boot_done = 1'b0;
        bus.mov = 1'b0; bus.r_w = 1'b0; bus.mtype = 2'b00; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (bus.mfc !== 1'b0) begin mismatched++; $display("FAIL reset_mfc: got %b want 0", bus.mfc); end
        compared++; if (bus.misalign_err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", bus.misalign_err); end
        compared++; if (bus.cpu_rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata); end
        compared++; if ({bus.ram_we, bus.ram_re} !== 2'b00) begin mismatched++; $display("FAIL reset_we_re: got %b want 00", {bus.ram_we, bus.ram_re}); end
        compared++; if (bus.ram_addr !== 9'h0 || bus.ram_wdata !== 8'h0) begin mismatched++; $display("FAIL reset_ram_bus: got %h/%h want 0/0", bus.ram_addr, bus.ram_wdata); end
        compared++; if ({bus.boot_ready, bus.boot_active} !== 2'b00) begin mismatched++; $display("FAIL reset_idle_boot_flags: got %b want 00", {bus.boot_ready, bus.boot_active}); end
        bus.boot_en = 1'b1;
        @(negedge clk);
        compared++; if ({bus.boot_ready, bus.boot_active} !== 2'b11) begin mismatched++; $display("FAIL reset_boot_flags: got %b want 11", {bus.boot_ready, bus.boot_active}); end
    endtask

    task automatic test_boot_and_word_read;
        int lat;
        logic held, mfc_after, err_after;
        logic [7:0] b;
        clr = 1'b1;
        bus.mov = 1'b1; bus.r_w = 1'b1; bus.mtype = 2'b10; bus.cpu_addr = 9'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b = 8'(8'h12 + 34 * i);
            bus.boot_valid = 1'b1; bus.boot_data = b;
            #1;
            compared++; if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 9'(i), b}) begin mismatched++; $display("FAIL boot_write%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", i, bus.ram_we, bus.ram_addr, bus.ram_wdata, i, b); end
            compared++; if (bus.mfc !== 1'b0) begin mismatched++; $display("FAIL boot_mov_ignored%0d: got mfc=%b want 0", i, bus.mfc); end
            exp_mem[i] = b;
        end
        @(negedge clk);
        bus.boot_valid = 1'b0; bus.boot_done = 1'b1;
        @(negedge clk);
        bus.boot_done = 1'b0;
        compared++; if ({bus.boot_active, bus.boot_ready, bus.mfc} !== 3'b000) begin mismatched++; $display("FAIL boot_done_idle: got act/rdy/mfc=%b want 000", {bus.boot_active, bus.boot_ready, bus.mfc}); end
        compared++; if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h12345678) begin mismatched++; $display("FAIL boot_ram: got %h want 12345678", {mem[0], mem[1], mem[2], mem[3]}); end
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.mfc && lat < 30);
        compared++; if (lat !== 6) begin mismatched++; $display("FAIL word_read_latency: got %0d want 6", lat); end
        exp_rd = exp_read(4, 0);
        compared++; if (bus.cpu_rdata !== exp_rd) begin mismatched++; $display("FAIL word_read_data: got %h want %h", bus.cpu_rdata, exp_rd); end
        finish_req(held, mfc_after, err_after);
        compared++; if (held !== 1'b1) begin mismatched++; $display("FAIL word_read_mfc_held: got %b want 1", held); end
        compared++; if (mfc_after !== 1'b0) begin mismatched++; $display("FAIL word_read_mfc_drop: got %b want 0", mfc_after); end
    endtask

    task automatic test_halfword_write;
        int lat, wes, res;
        logic held, mfc_after, err_after;
        do_req(1'b0, 2'b01, 9'h102, 32'h0000ABCD, lat, wes, res);
        exp_mem[9'h102] = 8'hAB; exp_mem[9'h103] = 8'hCD;
        compared++; if (lat !== 3) begin mismatched++; $display("FAIL hw_write_latency: got %0d want 3", lat); end
        compared++; if ({mem[9'h102], mem[9'h103]} !== 16'hABCD) begin mismatched++; $display("FAIL hw_write_ram: got %h want abcd", {mem[9'h102], mem[9'h103]}); end
        compared++; if (wes !== 2 || res !== 0) begin mismatched++; $display("FAIL hw_write_pulses: got we=%0d re=%0d want 2/0", wes, res); end
        compared++; if (bus.cpu_rdata !== exp_rd || bus.misalign_err !== 1'b0) begin mismatched++; $display("FAIL hw_write_rdata_err: got %h/%b want %h/0", bus.cpu_rdata, bus.misalign_err, exp_rd); end
        finish_req(held, mfc_after, err_after);
        compared++; if ({held, mfc_after} !== 2'b10) begin mismatched++; $display("FAIL hw_write_handshake: got %b want 10", {held, mfc_after}); end
    endtask

    task automatic test_byte_read;
        int lat, wes, res;
        logic held, mfc_after, err_after;
        logic [31:0] want;
`ifdef SPARC_MEM_SIGNEXT_EN
        want = 32'hFFFFFFAB;
`else
        want = 32'h000000AB;
`endif
        do_req(1'b1, 2'b00, 9'h102, 32'h0, lat, wes, res);
        exp_rd = want;
        compared++; if (lat !== 3) begin mismatched++; $display("FAIL byte_read_latency: got %0d want 3", lat); end
        compared++; if (bus.cpu_rdata !== want) begin mismatched++; $display("FAIL byte_read_data: got %h want %h", bus.cpu_rdata, want); end
        compared++; if (wes !== 0 || res !== 1) begin mismatched++; $display("FAIL byte_read_pulses: got we=%0d re=%0d want 0/1", wes, res); end
        finish_req(held, mfc_after, err_after);
        compared++; if ({held, mfc_after} !== 2'b10) begin mismatched++; $display("FAIL byte_read_handshake: got %b want 10", {held, mfc_after}); end
    endtask

    task automatic test_faults;
        int lat, wes, res;
        logic held, mfc_after, err_after;
        logic [1:0] t;
        logic [8:0] a;
        for (int c = 0; c < 2; c++) begin
            t = c == 0 ? 2'b10 : 2'b11;
            a = c == 0 ? 9'h006 : 9'h000;
            do_req(1'b1, t, a, 32'hDEADBEEF, lat, wes, res);
            compared++; if (lat !== 1) begin mismatched++; $display("FAIL fault%0d_latency: got %0d want 1", c, lat); end
            compared++; if (bus.misalign_err !== 1'b1) begin mismatched++; $display("FAIL fault%0d_err: got %b want 1", c, bus.misalign_err); end
            compared++; if (wes !== 0 || res !== 0) begin mismatched++; $display("FAIL fault%0d_pulses: got we=%0d re=%0d want 0/0", c, wes, res); end
            compared++; if (bus.cpu_rdata !== exp_rd) begin mismatched++; $display("FAIL fault%0d_rdata: got %h want %h", c, bus.cpu_rdata, exp_rd); end
            finish_req(held, mfc_after, err_after);
            compared++; if ({held, mfc_after, err_after} !== 3'b100) begin mismatched++; $display("FAIL fault%0d_handshake: got %b want 100", c, {held, mfc_after, err_after}); end
        end
    endtask

    task automatic test_boot_full;
        logic [7:0] b;
        @(negedge clk);
        clr = 1'b0; bus.boot_en = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        exp_rd = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            b = 8'($urandom);
            bus.boot_valid = 1'b1; bus.boot_data = b;
            exp_mem[i] = b;
            #1;
            if (i % 128 == 0 || i == DEPTH - 1) begin
                compared++; if ({bus.ram_we, bus.ram_addr} !== {1'b1, 9'(i)}) begin mismatched++; $display("FAIL boot_full_addr%0d: got we=%b a=%h want 1/%h", i, bus.ram_we, bus.ram_addr, i); end
            end
        end
        @(negedge clk);
        bus.boot_data = 8'hEE;
        #1;
        compared++; if ({bus.boot_ready, bus.boot_active, bus.ram_we} !== 3'b000) begin mismatched++; $display("FAIL boot_full_end: got rdy/act/we=%b want 000", {bus.boot_ready, bus.boot_active, bus.ram_we}); end
        @(negedge clk);
        bus.boot_valid = 1'b0;
        compared++; if (mem[0] !== exp_mem[0] || mem[DEPTH-1] !== exp_mem[DEPTH-1]) begin mismatched++; $display("FAIL boot_full_ram: got %h/%h want %h/%h", mem[0], mem[DEPTH-1], exp_mem[0], exp_mem[DEPTH-1]); end
        compared++; if (bus.cpu_rdata !== 32'h0) begin mismatched++; $display("FAIL boot_full_rdata: got %h want 0", bus.cpu_rdata); end
    endtask

    task automatic test_random;
        int lat, wes, res, nb, want_lat;
        logic held, mfc_after, err_after, rw, f;
        logic [1:0] t;
        logic [8:0] a;
        logic [31:0] wd;
        for (int it = 0; it < 40; it++) begin
            rw = 1'($urandom); t = 2'($urandom_range(0, 3)); wd = $urandom;
            nb = nbytes(t);
            a = 9'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) != 0) a = 9'((int'(a) / nb) * nb);
            f = is_fault(t, a);
            want_lat = f ? 1 : rw ? nb + 2 : nb + 1;
            do_req(rw, t, a, wd, lat, wes, res);
            if (!f && !rw) for (int i = 0; i < nb; i++) exp_mem[int'(a) + i] = 8'(wd >> (8 * (nb - 1 - i)));
            if (!f && rw) exp_rd = exp_read(nb, int'(a));
            compared++; if (lat !== want_lat) begin mismatched++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, want_lat); end
            compared++; if (bus.misalign_err !== f) begin mismatched++; $display("FAIL rand%0d_err: got %b want %b", it, bus.misalign_err, f); end
            compared++; if (wes !== ((f || rw) ? 0 : nb) || res !== ((f || !rw) ? 0 : nb)) begin mismatched++; $display("FAIL rand%0d_pulses: got we=%0d re=%0d", it, wes, res); end
            compared++; if (bus.cpu_rdata !== exp_rd) begin mismatched++; $display("FAIL rand%0d_rdata: got %h want %h", it, bus.cpu_rdata, exp_rd); end
            if (!f && !rw) for (int i = 0; i < nb; i++) begin
                compared++; if (mem[int'(a) + i] !== exp_mem[int'(a) + i]) begin mismatched++; $display("FAIL rand%0d_ram%0d: got %h want %h", it, i, mem[int'(a) + i], exp_mem[int'(a) + i]); end
            end
            finish_req(held, mfc_after, err_after);
            compared++; if ({held, mfc_after, err_after} !== 3'b100) begin mismatched++; $display("FAIL rand%0d_handshake: got %b want 100", it, {held, mfc_after, err_after}); end
        end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        bus.mov = 1'b1; bus.r_w = 1'b0; bus.mtype = 2'b10; bus.cpu_addr = 9'h010; bus.cpu_wdata = 32'hA1B2C3D4;
        repeat (2) @(negedge clk);
        clr = 1'b0; bus.mov = 1'b0; bus.boot_en = 1'b0;
        @(negedge clk);
        compared++; if ({bus.mfc, bus.misalign_err, bus.ram_we, bus.ram_re} !== 4'b0000) begin mismatched++; $display("FAIL midrst_flags: got %b want 0000", {bus.mfc, bus.misalign_err, bus.ram_we, bus.ram_re}); end
        compared++; if (bus.cpu_rdata !== 32'h0 || bus.ram_addr !== 9'h0 || bus.ram_wdata !== 8'h0) begin mismatched++; $display("FAIL midrst_buses: got %h/%h/%h want 0/0/0", bus.cpu_rdata, bus.ram_addr, bus.ram_wdata); end
        compared++; if ({bus.boot_ready, bus.boot_active} !== 2'b00) begin mismatched++; $display("FAIL midrst_state: got %b want 00", {bus.boot_ready, bus.boot_active}); end
        clr = 1'b1;
        exp_mem[9'h010] = 8'hA1; exp_mem[9'h011] = 8'hB2;
        @(negedge clk);
        compared++; if ({mem[9'h010], mem[9'h011], mem[9'h012], mem[9'h013]} !== {exp_mem[9'h010], exp_mem[9'h011], exp_mem[9'h012], exp_mem[9'h013]})
            begin mismatched++; $display("FAIL midrst_ram: got %h want %h", {mem[9'h010], mem[9'h011], mem[9'h012], mem[9'h013]}, {exp_mem[9'h010], exp_mem[9'h011], exp_mem[9'h012], exp_mem[9'h013]}); end
    endtask

    task automatic test_exclusive;
        compared++; if (both_cnt !== 0) begin mismatched++; $display("FAIL we_re_exclusive: got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'(i * 37 + 5);
            exp_mem[i] = 8'(i * 37 + 5);
        end
        test_reset;
        test_boot_and_word_read;
        test_halfword_write;
        test_byte_read;
        test_faults;
        test_boot_full;
        test_random;
        test_reset_mid_access;
        test_exclusive;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sparc_mem_ctrl.md
Name: sparc_mem_ctrl

Overview:
- Sequences all accesses to the byte-wide 512 x 8 main RAM of the SPARC MPU.
- Arbitrates between a boot-loader byte stream, used for preload after reset, and the control unit's MOV/MFC memory handshake.
- Splits CPU byte, halfword and word requests into big-endian byte accesses, then returns MFC when the access is complete.
- Sits between the control unit (CU), the datapath MAR/MDR, and the RAM array.

Parameters:
- ADDR_W, 9, RAM byte-address width.
- DEPTH, 512, RAM size in bytes. Must equal 2^ADDR_W.
- READ_LAT, 1, RAM read latency in cycles, from ram_re to ram_rdata valid. Legal values are 1 and 2.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Clr  in  1  reset; synchronous, active-low.
- boot_en  in  1  sampled during reset; 1 means enter BOOT, 0 means enter IDLE.
- boot_valid  in  1  boot byte present.
- boot_data  in  8  boot byte.
- boot_done  in  1  ends the boot phase early.
- boot_ready  out  1  controller accepts a boot byte this cycle.
- boot_active  out  1  high while in BOOT.
- mov  in  1  CPU memory-operation request; held until mfc.
- r_w  in  1  1 = read, 0 = write.
- type  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- cpu_addr  in  ADDR_W  byte address, taken from MAR.
- cpu_wdata  in  32  write data, taken from MDR and right-justified.
- cpu_rdata  out  32  read data, right-justified.
- mfc  out  1  memory function complete.
- misalign_err  out  1  the completed request was faulted.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  8  RAM write byte.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  8  RAM read byte.

Behaviour:
- Reset (Clr = 0 at a Clk edge):
  - State goes to BOOT if boot_en = 1, else IDLE. The boot counter is cleared to 0.
  - Outputs: mfc = 0, misalign_err = 0, cpu_rdata = 0, ram_we = 0, ram_re = 0, ram_addr = 0, ram_wdata = 0.
  - boot_ready and boot_active are 1 in BOOT and 0 otherwise.
  - Reset mid-access aborts the access; partial RAM writes stay in RAM.
- States: BOOT, IDLE, ACCESS, DONE.
- BOOT:
  - boot_ready = 1.
  - On boot_valid = 1, the same cycle drives ram_we = 1, ram_addr = counter, ram_wdata = boot_data, then counter increments.
  - The write to DEPTH-1 ends boot: next state is IDLE, and the counter wraps to 0.
  - boot_done = 1 also moves to IDLE next cycle. If boot_valid is high in the same cycle, that byte is written first.
  - mov is ignored in BOOT; the CPU simply waits and mfc stays 0.
- IDLE:
  - On mov = 1, latch r_w, type, cpu_addr and cpu_wdata.
  - N is the byte count: 1, 2 or 4.
  - A fault is type = 11, a halfword with addr[0] = 1, or a word with addr[1:0] != 0.
  - On a fault: go directly to DONE with misalign_err = 1 and make no RAM access.
  - Otherwise go to ACCESS.
- ACCESS, write:
  - Byte k (k = 0..N-1) is written in ACCESS cycle k at ram_addr = addr+k.
  - Data is big-endian: byte 0 is the most significant of the N bytes, e.g. cpu_wdata[31:24] for a word.
  - The write takes N cycles, then goes to DONE.
- ACCESS, read:
  - ram_re = 1 in ACCESS cycles 0..N-1, with ram_addr = addr+k.
  - Byte k is captured READ_LAT cycles after its issue and shifted in MSB-first.
  - ACCESS lasts N+READ_LAT cycles.
  - cpu_rdata is updated with the right-justified result on entry to DONE.
  - Upper bits are zero-extended unless the optional feature is enabled.
- DONE:
  - mfc = 1, and it is held while mov = 1 (four-phase handshake).
  - misalign_err stays valid while mfc = 1.
  - When mov = 0: next cycle go to IDLE, with mfc = 0 and misalign_err = 0.
  - cpu_rdata holds its value until the next read completes. Writes and faulted reads leave it unchanged.
- Latency, mov first seen in IDLE at cycle 0:
  - Write: mfc rises at cycle N+1.
  - Read: mfc rises at cycle N+READ_LAT+1.
  - Fault: mfc rises at cycle 1.
- Aligned accesses never cross DEPTH, so no address wrap is possible in ACCESS.
- ram_we and ram_re are never high together.

Optional Feature:
- Macro: SPARC_MEM_SIGNEXT_EN.
- When defined: byte and halfword reads sign-extend, from bit 7 or bit 15 respectively, into cpu_rdata[31:8] or [31:16].
- When undefined: those upper bits are 0.
- Write paths are identical in both builds.

Test Plan:
- Boot stream: boot_en = 1, 4 bytes 0x12,0x34,0x56,0x78 then boot_done. Expect RAM[0..3] = 12 34 56 78 and state IDLE the cycle after boot_done. A mov raised during boot gets no mfc until IDLE.
- Word read, addr 0, READ_LAT = 1: expect cpu_rdata = 0x12345678 and mfc rising 6 cycles after mov is sampled. mfc stays high until mov drops, then falls the next cycle.
- Halfword write: 0x0000ABCD at addr 0x102. Expect RAM[0x102] = 0xAB and RAM[0x103] = 0xCD, each with a one-cycle ram_we pulse, and mfc at cycle 3. A byte read of 0x102 then returns 0x000000AB, or 0xFFFFFFAB with SPARC_MEM_SIGNEXT_EN.
- Faults: word at addr 0x006, and type = 11 at addr 0. Expect mfc and misalign_err at cycle 1, no ram_we or ram_re pulse, and cpu_rdata unchanged.
- Boot full: stream 512 bytes with no boot_done. Expect the last write at 0x1FF, automatic move to IDLE, boot_ready = 0, and boot_valid ignored afterwards.
- Reset mid-access: Clr = 0 during cycle 2 of a word write. Expect next state BOOT or IDLE per boot_en, all outputs at reset values, bytes 0 and 1 written, and bytes 2 and 3 unchanged.
